ln_pass_sequencer: RTL and testbench
====================================

Name: ln_pass_sequencer

Overview:
- Multi-pass LayerNorm sequencer for one N-word vector buffer (BRAM), the VFU and a shared SFU.
- Loads N input words into BRAM, then sequences three read passes (SUM, VAR, NORM) with two SFU ops between them (mean divide, rsqrt of variance).
- Owns all BRAM addressing, VFU/SFU instruction issue, a_vec mux select and the start/done, input, output and SFU handshakes.

Parameters:
- N, 4, vector length in words; must be >= 2 and <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 2, BRAM address width.
- WIDTH, 16, datapath word width; documentation only, no logic depends on it.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one LayerNorm; sampled in IDLE only.
- in_valid  in  1  input word valid during LOAD.
- in_ready  out  1  sequencer accepts an input word.
- out_ready  in  1  downstream can take a normalized word next cycle.
- out_valid  out  1  normalized word on the VFU output this cycle.
- sfu_ack  in  1  SFU finished the requested op.
- sfu_req  out  1  SFU request, level, held until ack.
- write_addr  out  ADDR_WIDTH  BRAM write address.
- read_addr  out  ADDR_WIDTH  BRAM read address.
- write_enable  out  1  BRAM write strobe.
- a_vec_sel  out  1  0 = input_vec, 1 = BRAM read data.
- inst_vfu  out  2  00 NOP, 01 ACC, 10 SQDIFF_ACC, 11 NORM.
- inst_sfu  out  3  000 NOP, 001 DIV_N, 010 RSQRT.
- vfu_valid  out  1  VFU operand valid; aligned with BRAM read data.
- acc_clr  out  1  one-cycle VFU accumulator clear.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately, with no further writes or requests.
- All outputs are registered except in_ready, which is combinational: high iff state == LOAD.
- States: IDLE, LOAD, SUM, MEAN, VAR, RSQRT, NORM, DONE (3-bit).
- IDLE: start=1 -> LOAD, cnt=0, acc_clr pulses on the next cycle.
- LOAD:
  - Each cycle with in_valid & in_ready: write_enable=1 and write_addr=cnt on the next cycle, then cnt++. No write when in_valid=0.
  - a_vec_sel=0.
  - After the N-th accepted word -> SUM, cnt=0.
- SUM:
  - Issues read_addr=cnt on N consecutive cycles; a_vec_sel=1.
  - BRAM latency is 1 cycle, so vfu_valid=1 with inst_vfu=ACC exactly one cycle after each issue.
  - One drain cycle after the last issue -> MEAN. Phase length is N+1 cycles.
- MEAN:
  - sfu_req=1, inst_sfu=DIV_N, both held until sfu_ack. The sfu_ack cycle counts; an ack on the first cycle is legal.
  - On ack: sfu_req=0, acc_clr pulse, -> VAR.
- VAR: identical to SUM with inst_vfu=SQDIFF_ACC; -> RSQRT.
- RSQRT: as MEAN with inst_sfu=RSQRT; -> NORM, no acc_clr.
- NORM:
  - Issues a read only on cycles with out_ready=1; cnt advances only on issue.
  - One cycle after each issue: vfu_valid=1, inst_vfu=NORM, out_valid=1.
  - out_ready is a one-cycle-ahead credit: downstream must accept the beat that follows.
  - After N issues plus the drain -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- inst_vfu=NOP and vfu_valid=0 whenever no operand is in flight. inst_sfu=NOP whenever sfu_req=0.
- start while busy: ignored. sfu_ack outside MEAN/RSQRT: ignored. in_valid outside LOAD: ignored.
- cnt wraps only by explicit clear at phase entry; write_addr and read_addr never exceed N-1.

Optional Feature:
- Macro RMSNORM_MODE_EN.
- Defined:
  - Adds input port rms_mode (1 bit), sampled on start.
  - rms_mode=1: LOAD -> VAR directly (skips SUM and MEAN). VAR issues inst_vfu=10 with the mean register treated as zero by the VFU. acc_clr pulses on entry to VAR.
  - rms_mode=0: full LayerNorm flow.
- Undefined: no rms_mode port; full LayerNorm flow always.

Test Plan:
- Reset, then start with N=4 and in_valid held high -> write_addr 0,1,2,3 with write_enable on 4 consecutive cycles; SUM issues read_addr 0..3; vfu_valid with ACC lags each issue by 1 cycle.
- in_valid toggling 1,0,1,0... during LOAD -> exactly 4 writes, addresses 0..3, no write_enable in gap cycles.
- sfu_ack delayed 5 cycles in MEAN -> sfu_req and inst_sfu=001 held 5 cycles, acc_clr pulses once, then VAR starts; immediate ack in RSQRT also advances.
- out_ready pattern 1,0,0,1,1,0,1 in NORM -> exactly 4 out_valid beats, each 1 cycle after an out_ready=1 cycle; done pulses once; busy drops after.
- rst asserted mid-VAR -> all outputs 0 asynchronously; next start runs a clean full sequence from LOAD.
- RMSNORM_MODE_EN defined, rms_mode=1 -> no ACC or DIV_N activity; LOAD -> VAR -> RSQRT -> NORM -> done.

Source files
------------

// File: rtl/ln_pass_sequencer.sv
// LayerNorm pass sequencer: LOAD -> SUM -> MEAN -> VAR -> RSQRT -> NORM over one N-word BRAM.
// Optional RMSNORM_MODE_EN adds rms_mode, which skips SUM/MEAN and normalizes against a zero mean.
module ln_pass_sequencer #(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef RMSNORM_MODE_EN
  input  logic                  rms_mode,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  input  logic                  sfu_ack,
  output logic                  sfu_req,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  write_enable,
  output logic                  a_vec_sel,
  output logic [1:0]            inst_vfu,
  output logic [2:0]            inst_sfu,
  output logic                  vfu_valid,
  output logic                  acc_clr,
  output logic                  busy,
  output logic                  done
);

  if (N < 2 || N > (1 << ADDR_WIDTH) || WIDTH < 1) begin : g_param_check
    $error("ln_pass_sequencer: N must lie in [2, 2**ADDR_WIDTH]");
  end

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] VFU_NOP    = 2'b00;
  localparam logic [1:0] VFU_ACC    = 2'b01;
  localparam logic [1:0] VFU_SQDIFF = 2'b10;
  localparam logic [1:0] VFU_NORM   = 2'b11;
  localparam logic [2:0] SFU_NOP    = 3'b000;
  localparam logic [2:0] SFU_DIV_N  = 3'b001;
  localparam logic [2:0] SFU_RSQRT  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SUM, S_MEAN, S_VAR, S_RSQRT, S_NORM, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic                  write_enable_q, write_enable_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  a_vec_sel_q, a_vec_sel_d;
  logic [1:0]            inst_vfu_q, inst_vfu_d;
  logic [2:0]            inst_sfu_q, inst_sfu_d;
  logic                  vfu_valid_q, vfu_valid_d;
  logic                  acc_clr_q, acc_clr_d;
  logic                  sfu_req_q, sfu_req_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rms_sel;

`ifdef RMSNORM_MODE_EN
  logic rms_q, rms_d;
  assign rms_sel = rms_q;
`else
  assign rms_sel = 1'b0;
`endif

  assign cnt_inc  = cnt_q + ONE;
  assign in_ready = (state_q == S_LOAD);

  // read_addr is preloaded one cycle ahead, so the address shown in a cycle is the
  // address being issued in that cycle; vfu_valid follows one cycle later.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    read_addr_d    = read_addr_q;
    inst_vfu_d     = VFU_NOP;
    vfu_valid_d    = 1'b0;
    acc_clr_d      = 1'b0;
    out_valid_d    = 1'b0;
    done_d         = 1'b0;
`ifdef RMSNORM_MODE_EN
    rms_d          = rms_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          cnt_d     = '0;
          acc_clr_d = 1'b1;
`ifdef RMSNORM_MODE_EN
          rms_d     = rms_mode;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          write_enable_d = 1'b1;
          write_addr_d   = cnt_q[ADDR_WIDTH-1:0];
          if (cnt_q == LAST) begin
            cnt_d       = '0;
            read_addr_d = '0;
            state_d     = rms_sel ? S_VAR : S_SUM;
            acc_clr_d   = rms_sel;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_SUM, S_VAR: begin
        if (cnt_q == N_C) begin
          state_d = (state_q == S_SUM) ? S_MEAN : S_RSQRT;
        end else begin
          vfu_valid_d = 1'b1;
          inst_vfu_d  = (state_q == S_SUM) ? VFU_ACC : VFU_SQDIFF;
          cnt_d       = cnt_inc;
          if (cnt_q != LAST) read_addr_d = cnt_inc[ADDR_WIDTH-1:0];
        end
      end
      S_MEAN: begin
        if (sfu_ack) begin
          state_d     = S_VAR;
          cnt_d       = '0;
          read_addr_d = '0;
          acc_clr_d   = 1'b1;
        end
      end
      S_RSQRT: begin
        if (sfu_ack) begin
          state_d     = S_NORM;
          cnt_d       = '0;
          read_addr_d = '0;
        end
      end
      S_NORM: begin
        if (cnt_q == N_C) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (out_ready) begin
          // out_ready is a credit for the beat that appears next cycle
          vfu_valid_d = 1'b1;
          out_valid_d = 1'b1;
          inst_vfu_d  = VFU_NORM;
          cnt_d       = cnt_inc;
          if (cnt_q != LAST) read_addr_d = cnt_inc[ADDR_WIDTH-1:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Phase-level outputs are registered from the next state so they line up with it.
    busy_d      = (state_d != S_IDLE);
    a_vec_sel_d = (state_d == S_SUM) || (state_d == S_VAR) || (state_d == S_NORM);
    sfu_req_d   = (state_d == S_MEAN) || (state_d == S_RSQRT);
    inst_sfu_d  = (state_d == S_MEAN)  ? SFU_DIV_N :
                  (state_d == S_RSQRT) ? SFU_RSQRT : SFU_NOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      read_addr_q    <= '0;
      a_vec_sel_q    <= 1'b0;
      inst_vfu_q     <= VFU_NOP;
      inst_sfu_q     <= SFU_NOP;
      vfu_valid_q    <= 1'b0;
      acc_clr_q      <= 1'b0;
      sfu_req_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef RMSNORM_MODE_EN
      rms_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      read_addr_q    <= read_addr_d;
      a_vec_sel_q    <= a_vec_sel_d;
      inst_vfu_q     <= inst_vfu_d;
      inst_sfu_q     <= inst_sfu_d;
      vfu_valid_q    <= vfu_valid_d;
      acc_clr_q      <= acc_clr_d;
      sfu_req_q      <= sfu_req_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef RMSNORM_MODE_EN
      rms_q          <= rms_d;
`endif
    end
  end

  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign read_addr    = read_addr_q;
  assign a_vec_sel    = a_vec_sel_q;
  assign inst_vfu     = inst_vfu_q;
  assign inst_sfu     = inst_sfu_q;
  assign vfu_valid    = vfu_valid_q;
  assign acc_clr      = acc_clr_q;
  assign sfu_req      = sfu_req_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ln_pass_sequencer.sv
// Scoreboard bench for ln_pass_sequencer: a high-level model of one LayerNorm job queues the
// ordered events (writes, clears, VFU beats, SFU ops, done); a negedge monitor pops and compares.
module tb_ln_pass_sequencer;
  localparam int N  = 4;
  localparam int AW = 2;

  localparam int EV_WR   = 0;
  localparam int EV_CLR  = 1;
  localparam int EV_SFU  = 2;
  localparam int EV_VFU  = 3;
  localparam int EV_DONE = 4;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, in_valid, out_ready, sfu_ack;
  logic          in_ready, out_valid, sfu_req, write_enable, a_vec_sel;
  logic          vfu_valid, acc_clr, busy, done;
  logic [AW-1:0] write_addr, read_addr;
  logic [1:0]    inst_vfu;
  logic [2:0]    inst_sfu;
`ifdef RMSNORM_MODE_EN
  logic          rms_mode;
`endif

  int  checks   = 0;
  int  failures = 0;
  ev_t exp_q[$];
  bit  pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  // monitor history
  bit            prev_accept, prev_oready, chk_idle;
  logic [AW-1:0] prev_raddr;
  int            sfu_run;
  logic [2:0]    sfu_op0;

  ln_pass_sequencer #(.N(N), .ADDR_WIDTH(AW), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef RMSNORM_MODE_EN
    .rms_mode(rms_mode),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .sfu_ack(sfu_ack), .sfu_req(sfu_req), .write_addr(write_addr), .read_addr(read_addr),
    .write_enable(write_enable), .a_vec_sel(a_vec_sel), .inst_vfu(inst_vfu), .inst_sfu(inst_sfu),
    .vfu_valid(vfu_valid), .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void push(input int k, input int a, input int b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(input string nm, input int kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s unexpected event actual=%0d/%0d/%0d required=none (t=%0t)", nm, kind, a, b, $time);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
      chk({nm, "_a"}, a, e.a);
      chk({nm, "_b"}, b, e.b);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {write_enable, write_addr, read_addr, a_vec_sel, inst_vfu, inst_sfu,
            vfu_valid, acc_clr, busy, done, out_valid, sfu_req, in_ready};
  endfunction

  // Monitor: same-cycle events are processed in the order WR, CLR, SFU, VFU, DONE.
  always @(negedge clk) begin
    if (rst) begin
      prev_accept = 0; prev_oready = 0; prev_raddr = '0; sfu_run = 0; chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("busy_after_done", busy, 0);
        chk_idle = 0;
      end
      if (!sfu_req)   chk("inst_sfu_nop", inst_sfu, 0);
      if (!vfu_valid) begin
        chk("inst_vfu_nop", inst_vfu, 0);
        chk("out_valid_without_operand", out_valid, 0);
      end
      if (write_enable) begin
        chk("write_follows_accept", prev_accept, 1);
        pop_cmp("write", EV_WR, write_addr, 0);
      end
      if (acc_clr) pop_cmp("acc_clr", EV_CLR, 0, 0);
      if (sfu_req) begin
        if (sfu_run == 0) sfu_op0 = inst_sfu;
        sfu_run++;
        chk("sfu_op_held", inst_sfu, sfu_op0);
        if (sfu_ack) begin
          pop_cmp("sfu", EV_SFU, inst_sfu, sfu_run);
          sfu_run = 0;
        end
      end else begin
        sfu_run = 0;
      end
      if (vfu_valid) begin
        chk("a_vec_sel_bram", a_vec_sel, 1);
        chk("out_valid_iff_norm", out_valid, inst_vfu == 2'b11);
        if (out_valid) chk("out_credit", prev_oready, 1);
        pop_cmp("vfu", EV_VFU, inst_vfu, prev_raddr);
      end
      if (done) begin
        pop_cmp("done", EV_DONE, 0, 0);
        chk_idle = 1;
      end
      prev_accept = in_valid && in_ready;
      prev_oready = out_ready;
      prev_raddr  = read_addr;
    end
  end

  // One LayerNorm job. vmode: 0 in_valid high, 1 toggling, 2 random.
  // rmode: 0 out_ready high, 1 fixed pattern in NORM, 2 random. dm/dr: SFU ack delays.
  task automatic run_one(input bit rms, input int vmode, input int rmode,
                         input int dm, input int dr, input bit abort_var);
    int nack, need, req_cnt, pi, acks_total;
    bit tog, fin;
    // reference model of the job's observable event order
    push(EV_CLR, 0, 0);
    for (int i = 0; i < N; i++) push(EV_WR, i, 0);
    if (!rms) begin
      for (int i = 0; i < N; i++) push(EV_VFU, 1, i);
      push(EV_SFU, 1, dm);
    end
    push(EV_CLR, 0, 0);
    for (int i = 0; i < N; i++) push(EV_VFU, 2, i);
    push(EV_SFU, 2, dr);
    for (int i = 0; i < N; i++) push(EV_VFU, 3, i);
    push(EV_DONE, 0, 0);

    acks_total = rms ? 1 : 2;
    nack = 0; req_cnt = 0; pi = 0; tog = 1; fin = 0;
    @(posedge clk); #1;
    start = 1;
`ifdef RMSNORM_MODE_EN
    rms_mode = rms;
`endif
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(posedge clk); #1;
`ifdef RMSNORM_MODE_EN
      rms_mode = 1'($urandom_range(0, 1));
`endif
      if (done) begin
        fin = 1; start = 0; in_valid = 0; sfu_ack = 0; out_ready = 0;
      end else if (abort_var && vfu_valid && inst_vfu == 2'b10) begin
        #2 rst = 1;
        #1 chk("abort_outputs_zero", all_outs(), 0);
        exp_q.delete();
        start = 0; in_valid = 0; sfu_ack = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        fin = 1;
      end else begin
        start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        case (vmode)
          0:       in_valid = 1;
          1:       begin in_valid = tog; tog = ~tog; end
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        case (rmode)
          0: out_ready = 1;
          1: if (nack >= acks_total) begin out_ready = pat[pi % 7]; pi++; end
             else out_ready = 1;
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (sfu_req) begin
          req_cnt++;
          need = (rms || nack > 0) ? dr : dm;
          sfu_ack = (req_cnt >= need);
          if (sfu_ack) begin nack++; req_cnt = 0; end
        end else begin
          req_cnt = 0;
          sfu_ack = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!fin) begin
      checks++; failures++;
      $display("FAIL run_timeout actual=no_done required=done within 400 cycles");
      start = 0; in_valid = 0; sfu_ack = 0; out_ready = 0;
    end
    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; start = 0; in_valid = 0; out_ready = 0; sfu_ack = 0;
`ifdef RMSNORM_MODE_EN
    rms_mode = 0;
`endif
    #12 chk("reset_outputs", all_outs(), 0);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);

    run_one(0, 0, 0, 1, 1, 0);   // streaming load, immediate acks
    run_one(0, 1, 1, 5, 1, 0);   // gapped load, slow DIV_N, credit pattern in NORM
    run_one(0, 0, 2, 3, 2, 1);   // reset mid-VAR
    run_one(0, 2, 0, 2, 3, 0);   // clean job after abort
    for (int r = 0; r < 6; r++)
      run_one(0, 2, 2, $urandom_range(1, 6), $urandom_range(1, 6), 0);
`ifdef RMSNORM_MODE_EN
    run_one(1, 0, 1, 1, 4, 0);
    run_one(1, 2, 2, 1, $urandom_range(1, 5), 0);
    run_one(0, 2, 2, $urandom_range(1, 5), $urandom_range(1, 5), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
